// File: rtl/imem_loader.sv
// Framed byte-stream loader for the 16-bit instruction memory: length, big-endian
// payload words, XOR checksum. Keeps the CPU held until a frame loads cleanly.
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR
    } state_t;

    localparam logic [16:0] DEPTH_L   = 17'(DEPTH);
    localparam logic [15:0] ADDR_MASK = 16'((32'd1 << ADDR_W) - 32'd1);

    state_t      state;
    logic [15:0] word_cnt;
    logic [15:0] word_len;
    logic [7:0]  csum;
    logic [7:0]  hi_byte;
    logic        take;
    logic [7:0]  csum_next;
    logic [15:0] len_next;

    // Valid/ready: a byte moves only on a rising edge where in_valid && in_ready;
    // in_ready is a pure decode of the state register, so it never depends on in_valid.
    assign in_ready  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI)
                    || (state == DATA_LO) || (state == CSUM);
    assign busy      = in_ready;
    assign take      = in_valid && in_ready;
    assign csum_next = csum ^ in_byte;
    assign len_next  = {word_len[15:8], in_byte};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word_cnt  <= 16'd0;
            word_len  <= 16'd0;
            csum      <= 8'd0;
            hi_byte   <= 8'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (take) begin
                csum <= csum_next;
            end
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LEN_HI;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        csum     <= 8'd0;
                        word_cnt <= 16'd0;
                        cpu_hold <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (take) begin
                        word_len[15:8] <= in_byte;
                        state          <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (take) begin
                        word_len <= len_next;
                        if ({1'b0, len_next} > DEPTH_L) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else if (len_next == 16'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (take) begin
                        hi_byte <= in_byte;
                        state   <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (take) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_cnt & ADDR_MASK;
                        mem_wdata <= {hi_byte, in_byte};
                        word_cnt  <= word_cnt + 16'd1;
                        state     <= (word_cnt == word_len - 16'd1) ? CSUM : DATA_HI;
                    end
                end
                CSUM: begin
                    // csum_next folds in the checksum byte itself; a good frame XORs to zero.
                    if (take) begin
                        if (csum_next == 8'd0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table of whole frames, hand corner cases, and random
// frames checked against a frame-level XOR/word model.
module tb_imem_loader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          wtime_q[$];
    logic [15:0] frame_words[$];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_q.push_back({mem_addr, mem_wdata});
            wtime_q.push_back(cyc);
        end
    end

    typedef struct packed {
        logic [15:0]       n;
        logic [2:0][15:0]  w;
        logic [7:0]        csum;
        logic              gaps;
        logic              exp_done;
        logic              exp_err;
        logic              exp_hold;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [15:0] n, input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [7:0] c, input logic g,
                                input logic d, input logic e, input logic h);
        vec_t v;
        v.n = n; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.csum = c; v.gaps = g;
        v.exp_done = d; v.exp_err = e; v.exp_hold = h;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // XOR of length bytes and payload; the right checksum byte is this value.
    function automatic logic [7:0] frame_xor(input logic [15:0] n);
        logic [7:0] x;
        x = n[15:8] ^ n[7:0];
        foreach (frame_words[i]) x ^= frame_words[i][15:8] ^ frame_words[i][7:0];
        return x;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noise);
        int waited = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                start    = noise && ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        start    = noise && ($urandom_range(0, 3) == 0);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL ready_timeout: in_ready=%b expected 1 for byte %h", in_ready, b);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] n, input logic [7:0] csum, input bit gaps,
                             input bit noise);
        logic [7:0] b[$];
        b.push_back(n[15:8]);
        b.push_back(n[7:0]);
        if (n <= DEPTH) begin
            foreach (frame_words[i]) begin
                b.push_back(frame_words[i][15:8]);
                b.push_back(frame_words[i][7:0]);
                exp_q.push_back({16'(i), frame_words[i]});
            end
            b.push_back(csum);
        end
        pulse_start();
        foreach (b[k]) send_byte(b[k], gaps, noise);
    endtask

    task automatic check_status(input string name, input logic d, input logic e, input logic h);
        chk({name, "_done"}, 32'(done), 32'(d));
        chk({name, "_err"}, 32'(err), 32'(e));
        chk({name, "_hold"}, 32'(cpu_hold), 32'(h));
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic check_writes(input string name);
        @(negedge clk);
        chk({name, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({name, "_write"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
        wtime_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        logic [15:0] n;
        logic [7:0]  c;
        logic        good;

        vecs[0] = mk(16'd2,   16'h3CCF, 16'h318F, 16'h0000, 8'hF3, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[1] = mk(16'd257, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[2] = mk(16'd0,   16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[3] = mk(16'd1,   16'hABCD, 16'h0000, 16'h0000, 8'h67, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[4] = mk(16'd1,   16'hABCD, 16'h0000, 16'h0000, 8'h68, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[5] = mk(16'd3,   16'h1234, 16'h5678, 16'h9ABC, 8'h2D, 1'b1, 1'b1, 1'b0, 1'b0);

        // reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // back-to-back good frame, write pulse timing checked byte by byte
        pulse_start();
        send_byte(8'h00, 0, 0); send_byte(8'h02, 0, 0);
        send_byte(8'h3C, 0, 0); send_byte(8'hCF, 0, 0);
        chk("t1_we_w0", 32'(mem_we), 32'd1);
        chk("t1_addr_w0", 32'(mem_addr), 32'd0);
        chk("t1_wdata_w0", 32'(mem_wdata), 32'h3CCF);
        send_byte(8'h31, 0, 0);
        chk("t1_we_drop", 32'(mem_we), 32'd0);
        send_byte(8'h8F, 0, 0);
        send_byte(8'h4F, 0, 0);
        check_status("t1", 1'b1, 1'b0, 1'b0);
        chk("t1_we_after", 32'(mem_we), 32'd0);
        chk("t1_addr_hold", 32'(mem_addr), 32'd1);
        chk("t1_wdata_hold", 32'(mem_wdata), 32'h318F);
        if (wtime_q.size() == 2) chk("t1_spacing", 32'(wtime_q[1] - wtime_q[0]), 32'd2);
        else chk("t1_wtimes", 32'(wtime_q.size()), 32'd2);
        exp_q.push_back({16'd0, 16'h3CCF});
        exp_q.push_back({16'd1, 16'h318F});
        check_writes("t1");

        // vector table of whole frames
        for (int i = 0; i < 6; i++) begin
            frame_words.delete();
            if (vecs[i].n <= DEPTH)
                for (int k = 0; k < 3 && k < int'(vecs[i].n); k++) frame_words.push_back(vecs[i].w[k]);
            run_frame(vecs[i].n, vecs[i].csum, vecs[i].gaps, 1'b0);
            check_status($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_hold);
            check_writes($sformatf("vec%0d", i));
        end

        // 3 words with random in_valid gaps and start pulsed mid-frame
        frame_words = '{16'h1111, 16'h2222, 16'h3333};
        run_frame(16'd3, 8'h03, 1'b1, 1'b1);
        check_status("t5", 1'b1, 1'b0, 1'b0);
        check_writes("t5");

        // largest legal program
        frame_words.delete();
        for (int k = 0; k < DEPTH; k++) frame_words.push_back(16'($urandom));
        run_frame(16'(DEPTH), frame_xor(16'(DEPTH)), 1'b0, 1'b0);
        check_status("full", 1'b1, 1'b0, 1'b0);
        check_writes("full");

        // reset after DATA_HI of word 1
        pulse_start();
        send_byte(8'h00, 0, 0); send_byte(8'h02, 0, 0);
        send_byte(8'h3C, 0, 0); send_byte(8'hCF, 0, 0);
        send_byte(8'h31, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_ready", 32'(in_ready), 32'd0);
        chk("t6_we", 32'(mem_we), 32'd0);
        chk("t6_addr", 32'(mem_addr), 32'd0);
        chk("t6_wdata", 32'(mem_wdata), 32'd0);
        check_status("t6", 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        exp_q.push_back({16'd0, 16'h3CCF});
        check_writes("t6");
        frame_words = '{16'h3CCF, 16'h318F};
        run_frame(16'd2, 8'h4F, 1'b0, 1'b0);
        check_status("t6_reload", 1'b1, 1'b0, 1'b0);
        check_writes("t6_reload");

        // random frames against the frame-level model
        for (int r = 0; r < 25; r++) begin
            n = 16'($urandom_range(0, 6));
            frame_words.delete();
            for (int k = 0; k < int'(n); k++) frame_words.push_back(16'($urandom));
            good = ($urandom_range(0, 1) == 1);
            c = frame_xor(n);
            if (!good) c = c ^ 8'($urandom_range(1, 255));
            run_frame(n, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_status($sformatf("rnd%0d", r), good, !good, !good);
            check_writes($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
